// File: rtl/ffe_inst_sequencer.sv
// FFE instruction sequencer: issues estimator instructions, waits for the
// estimator to settle, then captures the tap vector. Also supports periodic
// auto-snapshots that are deferred behind (and coalesce during) commands.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a command or a pending auto-snapshot
//   ISSUE  | exec_inst high, inst driven with the latched opcode
//   SETTLE | quiet period letting the estimator outputs settle
//   SNAP   | one cycle; ffe_est is registered into snap_taps
module ffe_inst_sequencer #(
  parameter int est_depth     = 10,
  parameter int ffe_bitwidth  = 10,
  parameter int settle_cycles = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cmd_valid,
  output logic                                    cmd_ready,
  input  logic [2:0]                              cmd_op,
  input  logic [3:0]                              cmd_hold,
  input  logic [15:0]                             snap_period,
  output logic                                    exec_inst,
  output logic [2:0]                              inst,
  input  logic signed [est_depth*ffe_bitwidth-1:0] ffe_est,
  output logic signed [est_depth*ffe_bitwidth-1:0] snap_taps,
  output logic                                    snap_valid,
  input  logic                                    snap_ack,
  output logic                                    snap_overrun,
  output logic                                    busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] SNAP   = 2'd3;

  // A zero settle time still needs one SETTLE cycle to reach SNAP.
  localparam int         settle_eff  = (settle_cycles < 1) ? 1 : settle_cycles;
  localparam logic [15:0] settle_load = 16'(settle_eff - 1);

  logic [1:0]  state;
  logic [2:0]  op_q;
  logic [15:0] timer;
  logic [15:0] period_cnt;
  logic        auto_pending;

  logic        accept;
  logic        op_issues;
  logic        auto_fire;
  logic        period_hit;
  logic [15:0] hold_load;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);
  assign exec_inst = (state == ISSUE);
  // Only legal instruction opcodes ever reach ISSUE, so inst is never illegal.
  assign inst      = exec_inst ? op_q : 3'b000;

  // Decode the incoming command and the auto-snapshot trigger.
  always_comb begin
    op_issues  = (cmd_op == 3'b100) || (cmd_op == 3'b011) || (cmd_op == 3'b010);
    hold_load  = (cmd_hold < 4'd2) ? 16'd1 : ({12'd0, cmd_hold} - 16'd1);
    auto_fire  = (state == IDLE) && auto_pending && !accept;
    period_hit = (snap_period != 16'd0) && (period_cnt >= (snap_period - 16'd1));
  end

  // Main sequencing FSM with a shared down-counting phase timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q  <= 3'b000;
      timer <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= cmd_op;
            if (op_issues) begin
              state <= ISSUE;
              timer <= hold_load;
            end else begin
              state <= SETTLE;
              timer <= settle_load;
            end
          end else if (auto_pending) begin
            state <= SETTLE;
            timer <= settle_load;
          end
        end
        ISSUE: begin
          if (timer == 16'd0) begin
            state <= SETTLE;
            timer <= settle_load;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        SETTLE: begin
          if (timer == 16'd0) state <= SNAP;
          else                timer <= timer - 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running snapshot period counter; a new expiry wins over serving.
  always_ff @(posedge clk) begin
    if (rst || (snap_period == 16'd0)) begin
      period_cnt   <= 16'd0;
      auto_pending <= 1'b0;
    end else begin
      period_cnt <= period_hit ? 16'd0 : (period_cnt + 16'd1);
      if (period_hit)     auto_pending <= 1'b1;
      else if (auto_fire) auto_pending <= 1'b0;
    end
  end

  // Tap capture and the sticky unread/overrun flags; a capture beats an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_taps    <= '0;
      snap_valid   <= 1'b0;
      snap_overrun <= 1'b0;
    end else if (state == SNAP) begin
      snap_taps    <= ffe_est;
      snap_valid   <= 1'b1;
      snap_overrun <= snap_ack ? 1'b0 : (snap_overrun | snap_valid);
    end else if (snap_ack) begin
      snap_valid   <= 1'b0;
      snap_overrun <= 1'b0;
    end
  end

endmodule
